jtag_ir_driver: RTL and testbench

JTAG_IR_DRIVER -- requirements
Module: jtag_ir_driver

---
 rtl/jtag_ir_driver_if.sv | 35 +++
 rtl/jtag_ir_driver.sv | 173 +++++++++++++++++
 tb/tb_jtag_ir_driver.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_ir_driver_if.sv
// -----------------------------------------------------------------------------
// jtag_ir_driver_if
//   Bundles the request side and the TAP-facing serial side of the JTAG IR
//   driver.
//
//   Request side : start, instr, tap_reset (requests in); busy, done,
//                  captured (status out)
//   TAP side     : TMS, TDI (driver to target); TDO (target to driver)
//
//   slave  : the driver itself
//   master : whatever issues requests and hosts the target TAP
// -----------------------------------------------------------------------------
interface jtag_ir_driver_if #(
    parameter int IR_LEN = 8
);
    logic              start;
    logic [IR_LEN-1:0] instr;
    logic              tap_reset;
    logic              TDO;
    logic              TMS;
    logic              TDI;
    logic              busy;
    logic              done;
    logic [IR_LEN-1:0] captured;

    modport master (
        output start, instr, tap_reset, TDO,
        input  TMS, TDI, busy, done, captured
    );

    modport slave (
        input  start, instr, tap_reset, TDO,
        output TMS, TDI, busy, done, captured
    );
endinterface

// File: rtl/jtag_ir_driver.sv
// -----------------------------------------------------------------------------
// jtag_ir_driver
//   Drives a JTAG TAP to load an instruction into the target instruction
//   register, returning the previous IR contents, or walks the TAP through a
//   Test-Logic-Reset sequence.
//
//   Ports
//     TCLK     : the only clock, all state changes on its rising edge
//     TRESETN  : synchronous active-low reset
//     bus      : jtag_ir_driver_if.slave
//                start/instr   - request an IR load (taken only when idle)
//                tap_reset     - request a TAP reset (wins over start)
//                TDO           - serial data from the target
//                TMS/TDI       - registered TAP controls, TDI bit 0 first
//                busy          - a sequence is in progress
//                done          - one-cycle pulse at the end of an IR load
//                captured      - IR value shifted out during the last load
//
//   TMS and TDI are registered, so the value written on one edge is the value
//   the target samples on the following edge. state_q therefore follows the
//   target TAP state one edge behind the outputs: it names where the target
//   is after the current edge, while tms_q/tdi_q hold what it will see next.
// -----------------------------------------------------------------------------
module jtag_ir_driver #(
    parameter int IR_LEN     = 8,
    parameter int TLR_CYCLES = 5
) (
    input  logic TCLK,
    input  logic TRESETN,
    jtag_ir_driver_if.slave bus
);

    localparam int CNT_MAX  = (IR_LEN > TLR_CYCLES) ? IR_LEN : TLR_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    // Index of the bit presented after the first shift edge; guarded so that
    // IR_LEN=1 still elaborates (that path is never taken in that case).
    localparam int NEXT_BIT = (IR_LEN > 1) ? 1 : 0;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TLR_LAST = CNT_W'(TLR_CYCLES);
    localparam logic [CNT_W-1:0] IR_LAST  = CNT_W'(IR_LEN - 1);

    typedef enum logic [2:0] {
        TLR_SEQ,
        IDLE,
        SEL_DR,
        SEL_IR,
        CAPTURE,
        SHIFT,
        EXIT1,
        UPDATE
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IR_LEN-1:0] sr_q;
    logic [IR_LEN-1:0] cap_q;
    logic              tms_q;
    logic              tdi_q;
    logic              busy_q;
    logic              done_q;

    always_ff @(posedge TCLK) begin
        if (!TRESETN) begin
            state_q <= TLR_SEQ;
            cnt_q   <= '0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            cap_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // cnt_q counts TMS=1 edges already seen by the target; once
                // TLR_CYCLES are done, one TMS=0 edge lands it in Run-Test/Idle.
                TLR_SEQ: begin
                    tdi_q <= 1'b0;
                    if (cnt_q == TLR_LAST) begin
                        state_q <= IDLE;
                        tms_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                        tms_q <= ((cnt_q + CNT_ONE) != TLR_LAST);
                    end
                end

                // busy_q high in IDLE means a load was accepted on the
                // previous edge and the target is about to leave Run-Test/Idle.
                IDLE: begin
                    tdi_q <= 1'b0;
                    if (busy_q) begin
                        state_q <= SEL_DR;
                        tms_q   <= 1'b1;
                    end else if (bus.tap_reset) begin
                        state_q <= TLR_SEQ;
                        cnt_q   <= '0;
                        tms_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (bus.start) begin
                        sr_q   <= bus.instr;
                        tms_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end else begin
                        tms_q <= 1'b0;
                    end
                end

                SEL_DR: begin
                    state_q <= SEL_IR;
                    tms_q   <= 1'b0;
                end

                SEL_IR: begin
                    state_q <= CAPTURE;
                    tms_q   <= 1'b0;
                end

                // Target enters Shift-IR on this edge; present bit 0 for the
                // first shift edge, leaving at once if the IR is one bit long.
                CAPTURE: begin
                    state_q <= SHIFT;
                    cnt_q   <= '0;
                    tdi_q   <= sr_q[0];
                    tms_q   <= (IR_LEN == 1);
                end

                // cnt_q is the index of the bit the target is taking now.
                SHIFT: begin
                    cap_q <= IR_LEN'({bus.TDO, cap_q} >> 1);
                    sr_q  <= sr_q >> 1;
                    if (cnt_q == IR_LAST) begin
                        state_q <= EXIT1;
                        tms_q   <= 1'b1;
                        tdi_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                        tdi_q <= sr_q[NEXT_BIT];
                        tms_q <= ((cnt_q + CNT_ONE) == IR_LAST);
                    end
                end

                EXIT1: begin
                    state_q <= UPDATE;
                    tms_q   <= 1'b0;
                end

                UPDATE: begin
                    state_q <= IDLE;
                    tms_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end

                default: begin
                    state_q <= TLR_SEQ;
                    cnt_q   <= '0;
                    tms_q   <= 1'b1;
                    tdi_q   <= 1'b0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.TMS      = tms_q;
    assign bus.TDI      = tdi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.captured = cap_q;

endmodule

// File: tb/tb_jtag_ir_driver.sv
// -----------------------------------------------------------------------------
// tb_jtag_ir_driver
//   Bench for jtag_ir_driver with a behavioural 16-state target TAP whose
//   instruction register starts at 8'h3C.
// -----------------------------------------------------------------------------
module tb_jtag_ir_driver;

    localparam int L = 8;

    logic TCLK;
    logic TRESETN;

    jtag_ir_driver_if #(.IR_LEN(L)) bus ();

    jtag_ir_driver #(.IR_LEN(L), .TLR_CYCLES(5)) dut (
        .TCLK    (TCLK),
        .TRESETN (TRESETN),
        .bus     (bus)
    );

    initial TCLK = 1'b0;
    always #5 TCLK = ~TCLK;

    // ---------------- target TAP model ----------------
    typedef enum int {
        T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
        T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR
    } tap_t;

    tap_t         tap;
    logic [L-1:0] model_ir;
    logic [L-1:0] ir_sr;

    function automatic tap_t tap_next(input tap_t s, input logic tms);
        case (s)
            T_TLR:  return tms ? T_TLR  : T_RTI;
            T_RTI:  return tms ? T_SDR  : T_RTI;
            T_SDR:  return tms ? T_SIR  : T_CDR;
            T_CDR:  return tms ? T_E1DR : T_SHDR;
            T_SHDR: return tms ? T_E1DR : T_SHDR;
            T_E1DR: return tms ? T_UDR  : T_PDR;
            T_PDR:  return tms ? T_E2DR : T_PDR;
            T_E2DR: return tms ? T_UDR  : T_SHDR;
            T_UDR:  return tms ? T_SDR  : T_RTI;
            T_SIR:  return tms ? T_TLR  : T_CIR;
            T_CIR:  return tms ? T_E1IR : T_SHIR;
            T_SHIR: return tms ? T_E1IR : T_SHIR;
            T_E1IR: return tms ? T_UIR  : T_PIR;
            T_PIR:  return tms ? T_E2IR : T_PIR;
            T_E2IR: return tms ? T_UIR  : T_SHIR;
            default: return tms ? T_SDR : T_RTI;
        endcase
    endfunction

    initial begin
        tap      = T_TLR;
        model_ir = 8'h3C;
        ir_sr    = '0;
        bus.TDO  = 1'b0;
    end

    always @(posedge TCLK) begin
        if (tap == T_CIR)  ir_sr    <= model_ir;
        if (tap == T_SHIR) ir_sr    <= {bus.TDI, ir_sr[L-1:1]};
        if (tap == T_UIR)  model_ir <= ir_sr;
        tap <= tap_next(tap, bus.TMS);
    end

    always @(negedge TCLK) bus.TDO = (tap == T_SHIR) ? ir_sr[0] : 1'b0;

    // ---------------- checking ----------------
    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;
    int n_req  = 0;

    typedef struct {
        logic [L-1:0] cap;
        logic [L-1:0] ir;
    } exp_t;

    exp_t sb_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge TCLK) begin
        if (TRESETN === 1'b1 && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("done_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("captured", bus.captured, e.cap);
                check_eq("target_ir", model_ir, e.ir);
                n_done++;
            end
        end
    end

    function automatic logic exp_tms(input int k);
        if (k <= 2)         return 1'b1;
        if (k <= 4)         return 1'b0;
        if (k <= 4 + L)     return (k == 4 + L);
        if (k == 5 + L)     return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_tdi(input int k, input logic [L-1:0] v);
        if (k >= 5 && k <= 4 + L) return v[k-5];
        return 1'b0;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 100) begin
            @(negedge TCLK);
            n++;
        end
        if (n >= 100) check_eq("idle_timeout", 0, 1);
    endtask

    // Called on the negedge just before the first edge of a TAP-reset run.
    task automatic tlr_check(input bit poke);
        for (int k = 1; k <= 6; k++) begin
            check_eq("tlr_tms", bus.TMS, (k <= 5) ? 1 : 0);
            check_eq("tlr_tdi", bus.TDI, 0);
            check_eq("tlr_busy", bus.busy, 1);
            if (poke && k == 2) begin
                bus.instr = 8'hC3;
                bus.start = 1'b1;
            end
            if (poke && k == 3) bus.start = 1'b0;
            @(negedge TCLK);
        end
        check_eq("tlr_busy_end", bus.busy, 0);
        check_eq("tlr_tms_end", bus.TMS, 0);
        check_eq("tlr_target_rti", tap, T_RTI);
    endtask

    task automatic run_ir(input logic [L-1:0] v, input bit mid_start);
        exp_t e;
        wait_idle();
        e.cap = model_ir;
        e.ir  = v;
        sb_q.push_back(e);
        n_req++;
        bus.instr = v;
        bus.start = 1'b1;
        @(negedge TCLK);
        bus.start = 1'b0;
        for (int k = 1; k <= L + 6; k++) begin
            check_eq("ir_tms", bus.TMS, exp_tms(k));
            check_eq("ir_tdi", bus.TDI, exp_tdi(k, v));
            check_eq("ir_busy", bus.busy, 1);
            if (mid_start && k == 6) begin
                bus.instr = ~v;
                bus.start = 1'b1;
            end
            if (mid_start && k == 7) bus.start = 1'b0;
            @(negedge TCLK);
        end
        check_eq("ir_done", bus.done, 1);
        check_eq("ir_busy_end", bus.busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [L-1:0] ir0;
        TRESETN       = 1'b0;
        bus.start     = 1'b0;
        bus.tap_reset = 1'b0;
        bus.instr     = '0;
        repeat (3) @(negedge TCLK);
        check_eq("rst_tms", bus.TMS, 1);
        check_eq("rst_tdi", bus.TDI, 0);
        check_eq("rst_busy", bus.busy, 1);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_captured", bus.captured, 0);

        // Reset release: automatic TAP reset, start ignored meanwhile.
        TRESETN = 1'b1;
        tlr_check(1'b1);

        run_ir(8'hA5, 1'b0);
        check_eq("a5_target_ir", model_ir, 8'hA5);

        // Back-to-back loads; second start on the cycle after done.
        run_ir(8'h01, 1'b0);
        run_ir(8'h02, 1'b0);

        // start while busy is dropped.
        run_ir(8'h96, 1'b0 | 1'b1);
        repeat (3) @(negedge TCLK);
        check_eq("mid_start_idle", bus.busy, 0);

        // start and tap_reset together: the reset wins.
        wait_idle();
        ir0           = model_ir;
        bus.instr     = 8'h77;
        bus.start     = 1'b1;
        bus.tap_reset = 1'b1;
        @(negedge TCLK);
        bus.start     = 1'b0;
        bus.tap_reset = 1'b0;
        tlr_check(1'b0);
        check_eq("both_ir_unchanged", model_ir, ir0);

        // Reset asserted during bit 3 of a shift.
        wait_idle();
        bus.instr = 8'h5A;
        bus.start = 1'b1;
        @(negedge TCLK);
        bus.start = 1'b0;
        repeat (7) @(negedge TCLK);
        TRESETN = 1'b0;
        @(negedge TCLK);
        check_eq("abort_tms", bus.TMS, 1);
        check_eq("abort_busy", bus.busy, 1);
        check_eq("abort_done", bus.done, 0);
        check_eq("abort_tdi", bus.TDI, 0);
        check_eq("abort_captured", bus.captured, 0);
        @(negedge TCLK);
        TRESETN = 1'b1;
        tlr_check(1'b0);
        run_ir(8'hFF, 1'b0);
        check_eq("ff_target_ir", model_ir, 8'hFF);

        repeat (4) @(negedge TCLK);
        check_eq("done_count", n_done, n_req);
        check_eq("sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
